// File: rtl/conv_window_mem.sv
// conv_window_mem: loads an N x N matrix and a K x K filter through one write
// port, then sweeps every K x K window of the matrix, emitting one window row
// per beat together with the matching filter row and their dot product.
//
// Handshake (both streams): a beat transfers on a rising edge where valid and
// ready are both 1. The producer holds its payload stable while valid=1 and
// ready=0. On the write stream the DUT is the consumer (wr_ready); on the
// window stream it is the producer (win_valid) and ready may toggle freely.
module conv_window_mem #(
  parameter int DW = 8,
  parameter int N  = 4,
  parameter int K  = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DW-1:0]             data_w,
  input  logic                      wr_valid,
  input  logic                      wr_sel,
  output logic                      wr_ready,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      win_valid,
  input  logic                      win_ready,
  output logic [K*DW-1:0]           out_A,
  output logic [K*DW-1:0]           out_F,
  output logic [2*DW+$clog2(K)-1:0] psum,
  output logic [$clog2(N)-1:0]      win_row,
  output logic [$clog2(N)-1:0]      win_col,
  output logic [$clog2(K)-1:0]      tap_row,
  output logic [1:0]                dbg_state
);

  localparam int MA  = N * N;
  localparam int FA  = K * K;
  localparam int MAW = $clog2(MA);
  localparam int FAW = $clog2(FA);
  localparam int PW  = 2 * DW + $clog2(K);
  localparam int RW  = $clog2(N);
  localparam int KW  = $clog2(K);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;

  // Memory contents survive reset; only pointers and full flags are cleared.
  logic [DW-1:0]  mem_m [MA];
  logic [DW-1:0]  mem_f [FA];
  logic [MAW-1:0] ptr_m;
  logic [FAW-1:0] ptr_f;
  logic           full_m;
  logic           full_f;
  logic           wr_fire;
  logic           load_start;

  logic [RW-1:0]  nxt_row;
  logic [RW-1:0]  nxt_col;
  logic [KW-1:0]  nxt_tap;
  logic           last;
  logic [RW-1:0]  sel_row;
  logic [RW-1:0]  sel_col;
  logic [KW-1:0]  sel_tap;

  logic [K*DW-1:0] beat_a;
  logic [K*DW-1:0] beat_f;
  logic [PW-1:0]   beat_p;
  logic [DW-1:0]   a_j;
  logic [DW-1:0]   f_j;

  assign wr_ready   = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign dbg_state  = state;
  assign wr_fire    = wr_valid && wr_ready;
  assign load_start = (state == S_IDLE) && start && full_m && full_f;

  // Store accepted write beats at the selected memory's write pointer.
  always_ff @(posedge clk) begin
    if (!rst && wr_fire) begin
      if (wr_sel) mem_f[ptr_f] <= data_w;
      else        mem_m[ptr_m] <= data_w;
    end
  end

  // Advance write pointers; wrapping from the last address marks the memory full.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_m  <= '0;
      ptr_f  <= '0;
      full_m <= 1'b0;
      full_f <= 1'b0;
    end else if (wr_fire) begin
      if (wr_sel) begin
        if (ptr_f == FAW'(FA - 1)) begin
          ptr_f  <= '0;
          full_f <= 1'b1;
        end else begin
          ptr_f <= ptr_f + FAW'(1);
        end
      end else begin
        if (ptr_m == MAW'(MA - 1)) begin
          ptr_m  <= '0;
          full_m <= 1'b1;
        end else begin
          ptr_m <= ptr_m + MAW'(1);
        end
      end
    end
  end

  // Next sweep position: tap_row fastest, then win_col, then win_row.
  always_comb begin
    nxt_row = win_row;
    nxt_col = win_col;
    nxt_tap = tap_row;
    last    = (tap_row == KW'(K - 1)) && (win_col == RW'(N - K)) &&
              (win_row == RW'(N - K));
    if (tap_row == KW'(K - 1)) begin
      nxt_tap = '0;
      if (win_col == RW'(N - K)) begin
        nxt_col = '0;
        nxt_row = win_row + RW'(1);
      end else begin
        nxt_col = win_col + RW'(1);
      end
    end else begin
      nxt_tap = tap_row + KW'(1);
    end
  end

  // A fresh sweep loads position (0,0,0); otherwise the following position.
  always_comb begin
    sel_row = nxt_row;
    sel_col = nxt_col;
    sel_tap = nxt_tap;
    if (state == S_IDLE) begin
      sel_row = '0;
      sel_col = '0;
      sel_tap = '0;
    end
  end

  // Read the window row and filter row for the selected position and reduce them.
  always_comb begin
    beat_a = '0;
    beat_f = '0;
    beat_p = '0;
    a_j    = '0;
    f_j    = '0;
    for (int j = 0; j < K; j++) begin
      a_j = mem_m[MAW'((int'(sel_row) + int'(sel_tap)) * N + int'(sel_col) + j)];
      f_j = mem_f[FAW'(int'(sel_tap) * K + j)];
      beat_a[j*DW +: DW] = a_j;
      beat_f[j*DW +: DW] = f_j;
      beat_p = beat_p + PW'(a_j) * PW'(f_j);
    end
  end

  // Sweep control FSM; beat outputs only change when a beat is loaded or accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      win_valid <= 1'b0;
      done      <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
      tap_row   <= '0;
      out_A     <= '0;
      out_F     <= '0;
      psum      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (load_start) begin
            state     <= S_RUN;
            win_valid <= 1'b1;
            win_row   <= '0;
            win_col   <= '0;
            tap_row   <= '0;
            out_A     <= beat_a;
            out_F     <= beat_f;
            psum      <= beat_p;
          end
        end
        S_RUN: begin
          if (win_valid && win_ready) begin
            if (last) begin
              win_valid <= 1'b0;
              done      <= 1'b1;
              state     <= S_DONE;
            end else begin
              win_row <= nxt_row;
              win_col <= nxt_col;
              tap_row <= nxt_tap;
              out_A   <= beat_a;
              out_F   <= beat_f;
              psum    <= beat_p;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_mem.sv
// tb_conv_window_mem: directed sequence for conv_window_mem (N=4, K=3, DW=8)
// with a queue of expected window beats built from a reference model.
module tb_conv_window_mem;

  localparam int DW = 8;
  localparam int N  = 4;
  localparam int K  = 3;
  localparam int PW = 2 * DW + $clog2(K);
  localparam int RW = $clog2(N);
  localparam int KW = $clog2(K);
  localparam int BW = 2 * RW + KW + 2 * K * DW + PW;

  // ---------------- clock / reset / signals ----------------
  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   data_w;
  logic            wr_valid;
  logic            wr_sel;
  logic            wr_ready;
  logic            start;
  logic            busy;
  logic            done;
  logic            win_valid;
  logic            win_ready;
  logic [K*DW-1:0] out_A;
  logic [K*DW-1:0] out_F;
  logic [PW-1:0]   psum;
  logic [RW-1:0]   win_row;
  logic [RW-1:0]   win_col;
  logic [KW-1:0]   tap_row;
  logic [1:0]      dbg_state;

  always #5 clk = ~clk;

  conv_window_mem #(.DW(DW), .N(N), .K(K)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_w    (data_w),
    .wr_valid  (wr_valid),
    .wr_sel    (wr_sel),
    .wr_ready  (wr_ready),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .out_A     (out_A),
    .out_F     (out_F),
    .psum      (psum),
    .win_row   (win_row),
    .win_col   (win_col),
    .tap_row   (tap_row),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int             n_cmp = 0;
  int             n_fail = 0;
  int             beat_cnt = 0;
  int             done_cnt = 0;
  int             sweep_base = 0;
  bit             spot_on = 1'b0;
  logic [BW-1:0]  exp_q[$];
  logic [DW-1:0]  m_model [N*N];
  logic [DW-1:0]  f_model [K*K];
  logic           stall_prev = 1'b0;
  logic [BW-1:0]  prev_beat = '0;
  logic [BW-1:0]  cur_beat;

  assign cur_beat = {win_row, win_col, tap_row, out_A, out_F, psum};

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected beats for one full sweep, built straight from the window definition.
  task automatic push_sweep();
    logic [K*DW-1:0] a;
    logic [K*DW-1:0] f;
    logic [PW-1:0]   p;
    for (int r = 0; r <= N - K; r++) begin
      for (int c = 0; c <= N - K; c++) begin
        for (int t = 0; t < K; t++) begin
          a = '0;
          f = '0;
          p = '0;
          for (int j = 0; j < K; j++) begin
            a[j*DW +: DW] = m_model[(r + t) * N + c + j];
            f[j*DW +: DW] = f_model[t * K + j];
            p = p + PW'(m_model[(r + t) * N + c + j]) * PW'(f_model[t * K + j]);
          end
          exp_q.push_back({RW'(r), RW'(c), KW'(t), a, f, p});
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic write_beat(input logic sel, input logic [DW-1:0] d);
    wr_valid = 1'b1;
    wr_sel   = sel;
    data_w   = d;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input bit rnd_ready);
    for (int i = 0; i < 300; i++) begin
      if (done_cnt >= target) break;
      @(posedge clk);
      #1;
      if (rnd_ready) win_ready = ($urandom_range(0, 3) != 0);
    end
    win_ready = 1'b1;
    check("done_seen", 128'(done_cnt), 128'(target));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_win_valid"}, 128'(win_valid), 128'(0));
    check({tag, "_done"},      128'(done),      128'(0));
    check({tag, "_busy"},      128'(busy),      128'(0));
    check({tag, "_out_A"},     128'(out_A),     128'(0));
    check({tag, "_out_F"},     128'(out_F),     128'(0));
    check({tag, "_psum"},      128'(psum),      128'(0));
    check({tag, "_pos"},       128'({win_row, win_col, tap_row}), 128'(0));
    check({tag, "_state"},     128'(dbg_state), 128'(0));
  endtask

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    int idx;
    if (done) done_cnt++;
    if (win_valid && stall_prev) check("hold", 128'(cur_beat), 128'(prev_beat));
    if (win_valid && win_ready) begin
      idx = beat_cnt - sweep_base;
      check("beat_expected", 128'(exp_q.size() > 0), 128'(1));
      if (exp_q.size() > 0) check($sformatf("beat%0d", idx), 128'(cur_beat), 128'(exp_q.pop_front()));
      if (spot_on) begin
        if (idx == 0) begin
          check("first_out_A", 128'(out_A), 128'(24'h020100));
          check("first_out_F", 128'(out_F), 128'(24'h030201));
          check("first_psum",  128'(psum),  128'(8));
        end
        if (idx == 3) begin
          check("b4_pos",   128'({win_row, win_col, tap_row}), 128'({2'd0, 2'd1, 2'd0}));
          check("b4_out_A", 128'(out_A), 128'(24'h030201));
          check("b4_psum",  128'(psum),  128'(14));
        end
        if (idx == 11) begin
          check("last_pos",   128'({win_row, win_col, tap_row}), 128'({2'd1, 2'd1, 2'd2}));
          check("last_out_A", 128'(out_A), 128'(24'h0F0E0D));
          check("last_out_F", 128'(out_F), 128'(24'h090807));
          check("last_psum",  128'(psum),  128'(338));
        end
      end
      beat_cnt++;
    end
    stall_prev = win_valid && !win_ready;
    prev_beat  = cur_beat;
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [DW-1:0] d;
    rst = 1'b1; data_w = '0; wr_valid = 1'b0; wr_sel = 1'b0; start = 1'b0; win_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    check("reset_wr_ready", 128'(wr_ready), 128'(1));

    // Filter fully, matrix one short: start must be ignored.
    @(posedge clk); #1;
    for (int i = 0; i < K * K; i++) begin
      f_model[i] = DW'(i + 1);
      write_beat(1'b1, DW'(i + 1));
    end
    for (int i = 0; i < N * N - 1; i++) begin
      m_model[i] = DW'(i);
      write_beat(1'b0, DW'(i));
    end
    pulse_start();
    @(negedge clk);
    check("partial_start_busy",  128'(busy),      128'(0));
    check("partial_start_valid", 128'(win_valid), 128'(0));

    // 16th write, then a full sweep with win_ready held high.
    @(posedge clk); #1;
    m_model[N*N-1] = DW'(N * N - 1);
    write_beat(1'b0, DW'(N * N - 1));
    sweep_base = beat_cnt; spot_on = 1'b1; push_sweep();
    win_ready = 1'b1;
    pulse_start();
    @(negedge clk);
    check("start_win_valid", 128'(win_valid), 128'(1));
    check("start_busy",      128'(busy),      128'(1));
    @(posedge clk); #1;
    wait_done(1, 1'b0);
    check("sweep1_beats", 128'(beat_cnt - sweep_base), 128'(12));
    check("sweep1_q_empty", 128'(exp_q.size()), 128'(0));
    repeat (3) @(negedge clk);
    check("done_single", 128'(done_cnt), 128'(1));
    check("idle_wr_ready", 128'(wr_ready), 128'(1));

    // Restart without reloading; writes offered in RUN, 3-cycle stall mid-sweep.
    @(posedge clk); #1;
    sweep_base = beat_cnt; push_sweep();
    pulse_start();
    wr_valid = 1'b1; wr_sel = 1'b0; data_w = 8'hFF;
    @(negedge clk);
    check("run_wr_ready", 128'(wr_ready), 128'(0));
    check("run_state", 128'(dbg_state), 128'(1));
    repeat (3) begin @(posedge clk); #1; end
    win_ready = 1'b0;
    wr_sel = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    win_ready = 1'b1;
    wr_valid = 1'b0;
    wait_done(2, 1'b0);
    check("sweep2_beats", 128'(beat_cnt - sweep_base), 128'(12));
    check("sweep2_q_empty", 128'(exp_q.size()), 128'(0));

    // Reset mid-sweep at beat 5.
    @(posedge clk); #1;
    sweep_base = beat_cnt; push_sweep();
    pulse_start();
    for (int i = 0; i < 50; i++) begin
      if (beat_cnt - sweep_base >= 5) break;
      @(posedge clk); #1;
    end
    check("beats_before_rst", 128'(beat_cnt - sweep_base), 128'(5));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_all_zero("abort");
    check("abort_no_done", 128'(done_cnt), 128'(2));
    @(posedge clk); #1;
    pulse_start();
    @(negedge clk);
    check("no_reload_busy",  128'(busy),      128'(0));
    check("no_reload_valid", 128'(win_valid), 128'(0));

    // Reload with random contents and sweep under random backpressure.
    @(posedge clk); #1;
    spot_on = 1'b0;
    for (int i = 0; i < N * N; i++) begin
      d = DW'($urandom_range(0, 255));
      m_model[i] = d;
      write_beat(1'b0, d);
    end
    for (int i = 0; i < K * K; i++) begin
      d = DW'($urandom_range(0, 255));
      f_model[i] = d;
      write_beat(1'b1, d);
    end
    sweep_base = beat_cnt; push_sweep();
    pulse_start();
    wait_done(3, 1'b1);
    check("sweep4_beats", 128'(beat_cnt - sweep_base), 128'(12));
    check("sweep4_q_empty", 128'(exp_q.size()), 128'(0));
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_window_mem.md
CONV_WINDOW_MEM -- requirements
Module: conv_window_mem

Interface
REQ-001 Parameter DW, default 8: element data width in bits.
REQ-002 Parameter N, default 4: input matrix dimension (N x N elements); N >= K.
REQ-003 Parameter K, default 3: filter dimension (K x K elements); also the number of read lanes.
REQ-004 Port clk, input, 1: single clock, all state updates on its rising edge.
REQ-005 Port rst, input, 1: synchronous active-high reset.
REQ-006 Port data_w, input, DW: write data.
REQ-007 Port wr_valid, input, 1: write beat offered.
REQ-008 Port wr_sel, input, 1: write target; 0 = matrix, 1 = filter.
REQ-009 Port wr_ready, output, 1: write beat can be accepted.
REQ-010 Port start, input, 1: request a window sweep.
REQ-011 Port busy, output, 1: sweep in progress.
REQ-012 Port done, output, 1: one-cycle pulse when a sweep completes.
REQ-013 Port win_valid, output, 1: window-row beat valid.
REQ-014 Port win_ready, input, 1: consumer accepts the beat.
REQ-015 Port out_A, output, K*DW: K matrix elements of one window row; lane 0 in the LSBs.
REQ-016 Port out_F, output, K*DW: K filter elements of the matching filter row; lane 0 in the LSBs.
REQ-017 Port psum, output, 2*DW+clog2(K): unsigned sum over lanes of out_A[j]*out_F[j].
REQ-018 Ports win_row/win_col, output, clog2(N): output position of the beat. Port tap_row, output, clog2(K): filter row of the beat.

Function
REQ-019 States SHALL be IDLE, RUN and DONE; reset enters IDLE.
REQ-020 wr_ready SHALL be 1 only in IDLE; a beat is accepted when wr_valid and wr_ready are both 1.
REQ-021 Each memory SHALL have its own write pointer, starting at 0 and incremented per accepted beat; addressing is row-major (addr = row*N+col for the matrix, row*K+col for the filter).
REQ-022 A write to the last address (N*N-1 for the matrix, K*K-1 for the filter) SHALL wrap that pointer to 0 and set the memory's full flag; later writes overwrite from address 0 and the flag stays set.
REQ-023 start SHALL be accepted only in IDLE with both full flags set; otherwise it is ignored without effect.
REQ-024 Accepted start SHALL move to RUN with position (0,0) and tap_row 0; win_valid rises the next cycle.
REQ-025 All beat outputs SHALL be registered. For each beat: out_A lane j = M[(win_row+tap_row)*N + win_col + j]; out_F lane j = F[tap_row*K + j]; psum is computed from the same beat.
REQ-026 While win_valid=1 and win_ready=0, all beat outputs SHALL hold stable.
REQ-027 Sequencing: tap_row runs 0..K-1, then win_col runs 0..N-K, then win_row runs 0..N-K; a sweep is (N-K+1)^2*K beats.
REQ-028 On acceptance of the final beat: win_valid drops, the state moves to DONE, done=1 for exactly one cycle, then the state returns to IDLE.
REQ-029 Full flags SHALL persist after a sweep so that a repeat start is legal without reloading.
REQ-030 Writes offered in RUN or DONE SHALL be ignored, and pointers and contents stay unchanged.
REQ-031 busy SHALL be 1 in RUN and DONE.
REQ-032 psum SHALL not overflow: its width is sized for K full-scale products.

Reset
REQ-033 When rst=1 on a clock edge: state IDLE; pointers, full flags and position counters 0; win_valid, done and busy 0; out_A, out_F, psum, win_row, win_col and tap_row 0; wr_ready 1 on the following cycle.
REQ-034 Memory contents SHALL not be cleared by rst.
REQ-035 rst asserted mid-RUN SHALL abort the sweep with no done pulse; a new sweep then needs both memories reloaded.

Verification (N=4, K=3, DW=8)
REQ-036 Load matrix with M[i]=i (16 beats) and filter with F[i]=i+1 (9 beats), then start -> first beat: out_A={0,1,2}, out_F={1,2,3}, psum=8, position (0,0), tap_row 0.
REQ-037 Same load with win_ready=1 continuously -> exactly 12 beats; 4th beat: position (0,1), out_A={1,2,3}, psum=14; last beat: position (1,1), tap_row 2, out_A={13,14,15}, out_F={7,8,9}, psum=338; done pulses for 1 cycle.
REQ-038 Drop win_ready for 3 cycles mid-sweep -> all beat outputs hold stable; the sequence resumes with no beat skipped or duplicated.
REQ-039 start after 15 matrix writes -> ignored (busy stays 0); the 16th write followed by start -> sweep runs.
REQ-040 wr_valid=1 during RUN -> wr_ready=0 and no memory change; after done, a restart without reloading reproduces an identical 12-beat sequence.
REQ-041 rst at beat 5 -> all outputs 0 the next cycle with no done pulse; start before reload is ignored.
